// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        RELEASE  = 2'd2
    } state_e;

    // Key code bit position: row*4 + col, which is simply {row, col} for a 4x4 matrix.
    function automatic logic [3:0] onehot_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser bringing the asynchronous active-low rows into the clock domain.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_n_i,
    output logic [3:0] rows_sync_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Both stages idle high so an unpressed keypad is seen right out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= rows_n_i;
            sync_q <= meta_q;
        end
    end

    assign rows_sync_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: column strobing, press/release debounce, one-hot key handshake.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rows_n,
    output logic [3:0]  col_n,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_drop,
    output logic [7:0]  press_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rs;
    state_e           state_q;
    logic [1:0]       col_q;
    logic [3:0]       col_n_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cand_row_q;
    logic [3:0]       cand_pat_q;
    logic [15:0]      key_onehot_q;
    logic             key_valid_q;
    logic             key_drop_q;
    logic [7:0]       press_cnt_q;

    logic [3:0]       rows_low_d;
    logic             single_low_d;
    logic [1:0]       row_d;
    logic             accept_d;
    logic             consume_d;

    keypad_row_sync u_row_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rows_n_i   (rows_n),
        .rows_sync_o(rs)
    );

    // Decode the sampled rows: exactly one low row is a candidate, anything else is idle or ghosting.
    always_comb begin
        rows_low_d   = ~rs;
        single_low_d = (rows_low_d != 4'd0) && ((rows_low_d & (rows_low_d - 4'd1)) == 4'd0);
        row_d        = 2'd0;
        case (rows_low_d)
            4'b0001: row_d = 2'd0;
            4'b0010: row_d = 2'd1;
            4'b0100: row_d = 2'd2;
            4'b1000: row_d = 2'd3;
            default: row_d = 2'd0;
        endcase
        accept_d  = (state_q == DEBOUNCE) && (rs == cand_pat_q) && (cnt_q == DEB_LAST);
        consume_d = key_valid_q && key_ready;
    end

    // Scan/debounce FSM plus the key handshake; a consume in the same cycle as a new key frees the slot first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCAN;
            col_q        <= 2'd0;
            col_n_q      <= 4'b1110;
            cnt_q        <= '0;
            cand_row_q   <= 2'd0;
            cand_pat_q   <= 4'hF;
            key_onehot_q <= 16'h0000;
            key_valid_q  <= 1'b0;
            key_drop_q   <= 1'b0;
            press_cnt_q  <= 8'd0;
        end else begin
            key_drop_q <= 1'b0;
            if (consume_d) begin
                key_valid_q <= 1'b0;
            end
            if (accept_d) begin
                if (key_valid_q && !consume_d) begin
                    key_drop_q <= 1'b1;
                end else begin
                    key_onehot_q <= 16'd1 << onehot_idx(cand_row_q, col_q);
                    key_valid_q  <= 1'b1;
                    press_cnt_q  <= press_cnt_q + 8'd1;
                end
            end

            case (state_q)
                SCAN: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q <= '0;
                        if (single_low_d) begin
                            cand_row_q <= row_d;
                            cand_pat_q <= rs;
                            state_q    <= DEBOUNCE;
                        end else begin
                            col_q   <= col_q + 2'd1;
                            col_n_q <= {col_n_q[2:0], col_n_q[3]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rs != cand_pat_q) begin
                        cnt_q   <= '0;
                        state_q <= SCAN;
                        col_q   <= col_q + 2'd1;
                        col_n_q <= {col_n_q[2:0], col_n_q[3]};
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (rs != 4'hF) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= SCAN;
                        col_q   <= col_q + 2'd1;
                        col_n_q <= {col_n_q[2:0], col_n_q[3]};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign col_n      = col_n_q;
    assign key_onehot = key_onehot_q;
    assign key_valid  = key_valid_q;
    assign key_drop   = key_drop_q;
    assign press_cnt  = press_cnt_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rows_n;
    logic [3:0]  col_n;
    logic [15:0] key_onehot;
    logic        key_valid;
    logic        key_ready;
    logic        key_drop;
    logic [7:0]  press_cnt;

    logic [15:0] pressed;
    int          checks = 0;
    int          errors = 0;
    int          validRise;
    int          validHigh;
    int          dropCount;
    int          colChanges;
    logic        prevValid;
    logic [3:0]  prevCol;
    logic [15:0] seenKey;
    logic [3:0]  expCol;
    int          run;

    keypad_scan_ctrl #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows_n    (rows_n),
        .col_n     (col_n),
        .key_onehot(key_onehot),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_drop  (key_drop),
        .press_cnt (press_cnt)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) begin
                    rows_n[r] = 1'b0;
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearCounts();
        validRise  = 0;
        validHigh  = 0;
        dropCount  = 0;
        colChanges = 0;
        seenKey    = 16'h0000;
        prevValid  = key_valid;
        prevCol    = col_n;
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int n);
        pressed = mask;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) begin
                validHigh++;
                seenKey = key_onehot;
                if (!prevValid) validRise++;
            end
            if (key_drop) dropCount++;
            if (col_n != prevCol) colChanges++;
            prevValid = key_valid;
            prevCol   = col_n;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_ready = 1'b0;
        pressed   = 16'h0000;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_col_n", 32'(col_n), 32'(4'b1110));
        checkOutput("rst_key_onehot", 32'(key_onehot), 32'(16'h0000));
        checkOutput("rst_key_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("rst_key_drop", 32'(key_drop), 32'(1'b0));
        checkOutput("rst_press_cnt", 32'(press_cnt), 32'(8'd0));

        $display("[TB] test 1: idle column rotation");
        rst_n = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            if (k > 0) @(negedge clk);
            expCol = 4'hF ^ (4'b0001 << ((k / 4) % 4));
            checkOutput("t1_col_n", 32'(col_n), 32'(expCol));
        end
        checkOutput("t1_key_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("t1_key_onehot", 32'(key_onehot), 32'(16'h0000));

        $display("[TB] test 2: held key 6");
        key_ready = 1'b1;
        clearCounts();
        applyStimulus(16'h0040, 60);
        checkOutput("t2_valid_rises", 32'(validRise), 32'(1));
        checkOutput("t2_valid_cycles", 32'(validHigh), 32'(1));
        checkOutput("t2_seen_key", 32'(seenKey), 32'(16'h0040));
        checkOutput("t2_press_cnt", 32'(press_cnt), 32'(8'd1));
        checkOutput("t2_drops", 32'(dropCount), 32'(0));
        applyStimulus(16'h0000, 30);
        checkOutput("t2_valid_after", 32'(key_valid), 32'(1'b0));
        checkOutput("t2_onehot_kept", 32'(key_onehot), 32'(16'h0040));

        $display("[TB] test 3: bouncing key 3");
        clearCounts();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(16'h0008, 5);
            applyStimulus(16'h0000, 2);
        end
        checkOutput("t3_bursts_no_event", 32'(validRise), 32'(0));
        applyStimulus(16'h0008, 8);
        checkOutput("t3_early_no_event", 32'(validRise), 32'(0));
        applyStimulus(16'h0008, 52);
        checkOutput("t3_valid_rises", 32'(validRise), 32'(1));
        checkOutput("t3_seen_key", 32'(seenKey), 32'(16'h0008));
        checkOutput("t3_press_cnt", 32'(press_cnt), 32'(8'd2));
        applyStimulus(16'h0000, 30);

        $display("[TB] test 4: drop while key pending");
        key_ready = 1'b0;
        clearCounts();
        applyStimulus(16'h1000, 60);
        checkOutput("t4_a_valid", 32'(key_valid), 32'(1'b1));
        checkOutput("t4_a_onehot", 32'(key_onehot), 32'(16'h1000));
        checkOutput("t4_a_press_cnt", 32'(press_cnt), 32'(8'd3));
        checkOutput("t4_a_drops", 32'(dropCount), 32'(0));
        applyStimulus(16'h0000, 30);
        clearCounts();
        applyStimulus(16'h0020, 60);
        applyStimulus(16'h0000, 30);
        checkOutput("t4_b_drops", 32'(dropCount), 32'(1));
        checkOutput("t4_b_valid", 32'(key_valid), 32'(1'b1));
        checkOutput("t4_b_onehot", 32'(key_onehot), 32'(16'h1000));
        checkOutput("t4_b_press_cnt", 32'(press_cnt), 32'(8'd3));
        key_ready = 1'b1;
        applyStimulus(16'h0000, 1);
        key_ready = 1'b0;
        checkOutput("t4_consume_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("t4_consume_onehot", 32'(key_onehot), 32'(16'h1000));

        $display("[TB] test 5: ghosting in one column");
        clearCounts();
        applyStimulus(16'h0202, 60);
        checkOutput("t5_no_event", 32'(validRise), 32'(0));
        checkOutput("t5_no_drop", 32'(dropCount), 32'(0));
        checkOutput("t5_press_cnt", 32'(press_cnt), 32'(8'd3));
        checkOutput("t5_col_changes", 32'(colChanges), 32'(15));
        applyStimulus(16'h0000, 10);

        $display("[TB] test 6: reset during debounce");
        key_ready = 1'b1;
        pressed   = 16'h0800;
        run       = 0;
        for (int i = 0; i < 60 && run < 6; i++) begin
            @(negedge clk);
            if (col_n == 4'b0111) run++;
            else run = 0;
        end
        checkOutput("t6_in_debounce", 32'(run), 32'(6));
        checkOutput("t6_no_early_valid", 32'(key_valid), 32'(1'b0));
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_col_n", 32'(col_n), 32'(4'b1110));
        checkOutput("t6_rst_onehot", 32'(key_onehot), 32'(16'h0000));
        checkOutput("t6_rst_valid", 32'(key_valid), 32'(1'b0));
        checkOutput("t6_rst_drop", 32'(key_drop), 32'(1'b0));
        checkOutput("t6_rst_press_cnt", 32'(press_cnt), 32'(8'd0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearCounts();
        applyStimulus(16'h0800, 60);
        checkOutput("t6_valid_rises", 32'(validRise), 32'(1));
        checkOutput("t6_seen_key", 32'(seenKey), 32'(16'h0800));
        checkOutput("t6_press_cnt", 32'(press_cnt), 32'(8'd1));
        applyStimulus(16'h0000, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer for the 4x4 matrix keypad. It drives one column low at a time, samples the active-low rows and debounces both press and release. Each debounced press becomes a 16-bit one-hot key code with a valid/ready handshake. Its key_onehot output feeds the one-hot-to-binary encoder, which holds its output whenever the one-hot input is idle.

Parameters:
SETTLE_CYCLES, 4, cycles each column stays driven before rows are sampled (>=3, covers the 2-flop sync).
DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a press or a release (>=2).
CNT_W, 16, width of the internal settle/debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rows_n  in  4  keypad rows, active-low, asynchronous to clk.
col_n  out  4  column strobes, active-low, exactly one low at any time.
key_onehot  out  16  debounced key; bit = row*4 + col.
key_valid  out  1  key_onehot holds a new, unconsumed key.
key_ready  in  1  consumer accepts the key when key_valid && key_ready.
key_drop  out  1  one-cycle pulse: a debounced key was discarded because key_valid was still high.
press_cnt  out  8  count of accepted presses, wraps 255->0.

Behaviour:
- Reset (async assert, sync release) values:
  - col_n=4'b1110; key_onehot=16'h0000; key_valid=0; key_drop=0; press_cnt=0.
  - State=SCAN, column index=0, counters=0, synchroniser flops=4'hF.
- rows_n passes through a 2-flop synchroniser. All decisions use the synchronised value rs.
- SCAN:
  - The current column is held for SETTLE_CYCLES cycles. On the last cycle rs is sampled.
  - Exactly one bit of rs low: latch candidate (col, row) and go to DEBOUNCE. The column stays driven.
  - rs all high, or more than one bit low (ghosting/invalid): advance the column (3 wraps to 0), reset the settle counter, stay in SCAN.
- DEBOUNCE:
  - Counter increments each cycle rs equals the candidate pattern.
  - Any mismatch: back to SCAN, advance the column, no event.
  - Counter reaches DEBOUNCE_CYCLES: key accepted.
    - If key_valid=0: in the next cycle key_onehot gets the candidate bit, key_valid=1, press_cnt+1.
    - If key_valid=1: key_onehot unchanged, key_drop pulses one cycle, press_cnt unchanged.
  - Either way, go to RELEASE.
- RELEASE:
  - Column stays driven. Counter counts consecutive cycles with rs==4'hF; any low bit clears it.
  - Reaching DEBOUNCE_CYCLES: go to SCAN and advance the column.
  - A held key produces exactly one event.
- Handshake:
  - key_valid falls the cycle after valid&&ready.
  - key_onehot is stable while key_valid=1 and keeps the last key after the handshake (never returns to 0 except on reset).
  - If an accept and a new key occur in the same cycle, the accept takes effect first: new key loads, key_valid stays 1, no drop.
  - key_ready is ignored while key_valid=0.
- Latency: press stable on the active column -> key_valid high <= SETTLE_CYCLES + DEBOUNCE_CYCLES + 3 cycles.
- rst_n asserted mid-debounce or mid-handshake: immediate return to reset values, no partial event.

Decomposition:
- keypad_pkg:
  - state enum {SCAN, DEBOUNCE, RELEASE}.
  - NUM_ROWS=4, NUM_COLS=4.
  - Function onehot_idx(row, col) = row*4+col.
- Sub-module keypad_row_sync: 4-bit 2-flop synchroniser, reset to 4'hF.
- FSM, counters and handshake stay in keypad_scan_ctrl.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8):
1. Reset, no keys, run 64 cycles -> col_n cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid=0; key_onehot=0000.
2. Hold row1/col2 (key 6) for 40 cycles with key_ready=1 -> one key_valid pulse; key_onehot=16'h0040; press_cnt=1; no second event while held.
3. Bounce row0/col3 for 5 on / 2 off cycles, then stable -> a single key with key_onehot=16'h0008 only after 8 stable cycles; earlier bursts give no event.
4. key_ready=0; press key A (row3/col0, 16'h1000), release, press key B -> key_valid stays 1 with 16'h1000; key_drop pulses once; press_cnt=1.
5. Two rows low in the same column -> no event; scanning continues; col_n keeps rotating.
6. Assert rst_n mid-DEBOUNCE -> all outputs at reset values the same cycle; a normal press after deassert is accepted with press_cnt=1.
